// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential HI/LO divider.
// The state encodings match the values used elsewhere in the core.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division iteration on magnitudes: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, emit one quotient bit.
module div_seq_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // A borrow out of the extra top bit means the trial subtraction went negative.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (diff[DATA_W]) begin
      rem_o = shifted[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end else begin
      rem_o = diff[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for DIV/DIVU: one quotient bit per clock,
// result {remainder(HI), quotient(LO)} held while ready_o is high.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  op1_neg_q, op1_neg_d;
  logic                  op2_neg_q, op2_neg_d;
  logic                  signed_q, signed_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     step_rem;
  logic [DATA_W-1:0]     step_quo;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic en);
    return (en && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  div_seq_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    op1_neg_d = op1_neg_q;
    op2_neg_d = op2_neg_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        // Magnitudes go into the datapath; signs are reapplied at the end.
        if (start_i == DivStart && !annul_i) begin
          op1_neg_d = opdata1_i[DATA_W-1];
          op2_neg_d = opdata2_i[DATA_W-1];
          signed_d  = signed_i;
          rem_d     = '0;
          quo_d     = abs_val(opdata1_i, signed_i);
          divisor_d = abs_val(opdata2_i, signed_i);
          cnt_d     = '0;
          state_d   = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end

      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          // The final step feeds the sign fix-up directly so the result lands with ready.
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DivEnd;
            cnt_d    = '0;
            result_d = {neg_if(step_rem, signed_q & op1_neg_q),
                        neg_if(step_quo, signed_q & (op1_neg_q ^ op2_neg_q))};
            ready_d  = DivResultReady;
          end
        end
      end

      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      op1_neg_q <= op1_neg_d;
      op2_neg_q <= op2_neg_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Stall is raised in the accept cycle itself, before the state register moves.
  assign busy_o   = (state_q == DivFree && start_i && !annul_i) ||
                    state_q == DivOn || state_q == DivByZero;
  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results are queued at issue time and
// a separate monitor compares them whenever ready_o rises.
module tb_div_seq;
  import div_seq_pkg::*;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic            annul_i;
  logic            signed_i;
  logic [W-1:0]    opdata1_i;
  logic [W-1:0]    opdata2_i;
  logic [2*W-1:0]  result_o;
  logic            ready_o;
  logic            busy_o;

  typedef struct {
    logic [2*W-1:0] res;
    string          name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic ready_prev = 1'b0;

  div_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Monitor: every rising edge of ready_o must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ready_o && !ready_prev) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_result actual=%h required=no_result", result_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result_o !== e.res) begin
          failures++;
          $display("[TB] FAIL result_%s actual=%h required=%h", e.name, result_o, e.res);
        end
      end
    end
    ready_prev = ready_o;
  end

  task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                             input logic [2*W-1:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // One full EX handshake; latency counts edges from the request, accept edge included.
  task automatic applyStimulus(input string name, input logic sgn,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] exp_res, input int exp_edges,
                               input int hold);
    exp_t e;
    int   edges;
    logic busy_ok;
    e.res  = exp_res;
    e.name = name;
    sb_q.push_back(e);
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    busy_ok = busy_o;
    @(posedge clk); #1;
    opdata1_i = ~a;
    opdata2_i = '0;
    signed_i  = ~sgn;
    edges = 1;
    while (!ready_o && edges < 100) begin
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({name, "_latency"}, 64'(edges), 64'(exp_edges));
    checkOutput({name, "_busy_while_dividing"}, 64'(busy_ok), 64'(1));
    checkOutput({name, "_busy_at_end"}, 64'(busy_o), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({name, "_hold_ready"}, 64'(ready_o), 64'(1));
      checkOutput({name, "_hold_result"}, result_o, exp_res);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, "_ready_drop"}, 64'(ready_o), 64'(0));
    checkOutput({name, "_result_clear"}, result_o, 64'(0));
  endtask

  initial begin
    logic quiet;
    rst       = 1'b1;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(ready_o), 64'(0));
    checkOutput("reset_result", result_o, 64'(0));
    checkOutput("reset_busy", 64'(busy_o), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}, 33, 0);
    applyStimulus("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    applyStimulus("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
    applyStimulus("div_m7_m2",    1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h0000_0003}, 33, 0);
    applyStimulus("divu_5_0",     1'b0, 32'd5,          32'd0,          64'd0, 2, 0);
    applyStimulus("div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          64'd0, 2, 0);
    applyStimulus("divu_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}, 33, 0);
    applyStimulus("divu_max_16",  1'b0, 32'hFFFF_FFFF,  32'h10,         {32'h0000_000F, 32'h0FFF_FFFF}, 33, 0);
    applyStimulus("divu_min_max", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}, 33, 0);

    // Flush on the tenth DivOn edge; no result may ever appear for it.
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    checkOutput("annul_busy", 64'(busy_o), 64'(0));
    checkOutput("annul_ready", 64'(ready_o), 64'(0));
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o || busy_o) quiet = 1'b0;
    end
    checkOutput("annul_stays_idle", 64'(quiet), 64'(1));
    applyStimulus("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

    // Reset on the fifth DivOn edge aborts the divide.
    start_i   = 1'b1;
    signed_i  = 1'b1;
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset_ready", 64'(ready_o), 64'(0));
    checkOutput("midreset_result", result_o, 64'(0));
    checkOutput("midreset_busy", 64'(busy_o), 64'(0));
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) quiet = 1'b0;
    end
    checkOutput("midreset_no_result", 64'(quiet), 64'(1));
    applyStimulus("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0);

    applyStimulus("divu_hold", 1'b0, 32'd1234567, 32'd1000, {32'd567, 32'd1234}, 33, 3);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
